// File: rtl/class_input_fifo.sv
// Per-class ingress FIFO feeding one scheduler input. Releases one registered
// word per accepted pop and drives an all-zero word otherwise, which the
// scheduler treats as an idle slot. Occupancy lives in its own counter, so
// pointer equality never has to tell full from empty.
module class_input_fifo #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned ALMOST_FULL  = 6,
  parameter int unsigned ALMOST_EMPTY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DepthCnt = CntW'(Depth);
  localparam logic [ADDR_WIDTH:0] AfCnt    = CntW'(ALMOST_FULL);
  localparam logic [ADDR_WIDTH:0] AeCnt    = CntW'(ALMOST_EMPTY);

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_out_q, overflow_q, underflow_q;
  logic                  push_ok, pop_ok;

  // Pop needs a stored word (no fall-through); a push into a full FIFO is
  // accepted only when a pop frees a slot in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Flags come from the count register alone, i.e. state after the last edge.
  assign full         = (count_q == DepthCnt);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AfCnt);
  assign almost_empty = (count_q <= AeCnt);

  assign count     = count_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are unobservable after reset so it is not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // Pointers, occupancy, registered output word and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (pop_ok) begin
        data_out_q  <= mem[rd_ptr_q];
        valid_out_q <= 1'b1;
        rd_ptr_q    <= rd_ptr_q + ADDR_WIDTH'(1);
      end else begin
        data_out_q  <= '0;
        valid_out_q <= 1'b0;
      end
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_class_input_fifo.sv
// Bench for class_input_fifo: table-driven fill/drain with wrap, hand-written
// corner sequences, and a scoreboard queue of expected output words.
module tb_class_input_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic [3:0]  count;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;

  class_input_fifo #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (3),
    .ALMOST_FULL (6),
    .ALMOST_EMPTY(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [15:0] data;
    logic        pop;
    logic [3:0]  exp_count;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state and scoreboard of expected {valid, data}.
  logic [15:0] mdl[$];
  logic [16:0] sb[$];
  logic        m_over = 1'b0;
  logic        m_under = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: update model, drive, sample #1 after the edge, compare.
  task automatic step(input logic p, input logic [15:0] d, input logic q);
    logic        pop_ok, push_ok;
    logic [16:0] e;
    int          sz;
    sz      = mdl.size();
    pop_ok  = q && (sz > 0);
    push_ok = p && ((sz < 8) || pop_ok);
    sb.push_back({pop_ok, pop_ok ? mdl[0] : 16'h0000});
    if (pop_ok) void'(mdl.pop_front());
    if (push_ok) mdl.push_back(d);
    if (p && !push_ok) m_over = 1'b1;
    if (q && !pop_ok) m_under = 1'b1;
    push = p; data_in = d; pop = q;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; data_in = 16'h0000;
    e = sb.pop_front();
    chk("valid_out", {31'd0, valid_out}, {31'd0, e[16]});
    chk("data_out", {16'd0, data_out}, {16'd0, e[15:0]});
    chk("count", {28'd0, count}, mdl.size());
    chk("full", {31'd0, full}, {31'd0, mdl.size() == 8});
    chk("empty", {31'd0, empty}, {31'd0, mdl.size() == 0});
    chk("almost_full", {31'd0, almost_full}, {31'd0, mdl.size() >= 6});
    chk("almost_empty", {31'd0, almost_empty}, {31'd0, mdl.size() <= 2});
    chk("overflow", {31'd0, overflow}, {31'd0, m_over});
    chk("underflow", {31'd0, underflow}, {31'd0, m_under});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_data_out"}, {16'd0, data_out}, 32'd0);
    chk({tag, "_valid_out"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_count"}, {28'd0, count}, 32'd0);
    chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
    chk({tag, "_almost_empty"}, {31'd0, almost_empty}, 32'd1);
    chk({tag, "_full"}, {31'd0, full}, 32'd0);
    chk({tag, "_almost_full"}, {31'd0, almost_full}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_underflow"}, {31'd0, underflow}, 32'd0);
  endtask

  vec_t vecs[22];

  initial begin
    // Fill 1..8, pop 3, push 9..B (wraps wr_ptr), pop 8 (wraps rd_ptr).
    for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, 16'(i + 1), 1'b0, 4'(i + 1), 1'b0, 16'h0};
    for (int i = 0; i < 3; i++) vecs[8 + i] = '{1'b0, 16'h0, 1'b1, 4'(7 - i), 1'b1, 16'(i + 1)};
    for (int i = 0; i < 3; i++) vecs[11 + i] = '{1'b1, 16'(9 + i), 1'b0, 4'(6 + i), 1'b0, 16'h0};
    for (int i = 0; i < 8; i++) vecs[14 + i] = '{1'b0, 16'h0, 1'b1, 4'(7 - i), 1'b1, 16'(4 + i)};

    rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].push, vecs[i].data, vecs[i].pop);
      chk("vec_count", {28'd0, count}, {28'd0, vecs[i].exp_count});
      chk("vec_valid", {31'd0, valid_out}, {31'd0, vecs[i].exp_valid});
      chk("vec_data", {16'd0, data_out}, {16'd0, vecs[i].exp_data});
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Full push+pop: pop returns head, push of 0x00AA accepted, no overflow.
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b1, 16'h00AA, 1'b1);
    chk("fpp_data", {16'd0, data_out}, 32'h0001);
    chk("fpp_count", {28'd0, count}, 32'd8);
    chk("fpp_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    chk("fpp_8th", {16'd0, data_out}, 32'h00AA);

    // Overflow: 0xDEAD dropped, never seen on data_out.
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b1, 16'hDEAD, 1'b0);
    chk("ovf_count", {28'd0, count}, 32'd8);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 16'h0, 1'b1);
      chk("ovf_drain", {16'd0, data_out}, 32'(i));
    end

    // Empty push+pop: no fall-through, underflow, word retained.
    step(1'b1, 16'h0055, 1'b1);
    chk("epp_valid", {31'd0, valid_out}, 32'd0);
    chk("epp_data", {16'd0, data_out}, 32'd0);
    chk("epp_underflow", {31'd0, underflow}, 32'd1);
    chk("epp_count", {28'd0, count}, 32'd1);
    step(1'b0, 16'h0, 1'b1);
    chk("epp_next", {16'd0, data_out}, 32'h0055);

    // Idle slots: ten cycles without pop keep the output zero.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 16'h0, 1'b0);
      chk("idle_data", {16'd0, data_out}, 32'd0);
    end

    // Async reset mid-cycle with count=5, valid word on output and pop held.
    for (int i = 1; i <= 6; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b1);
    chk("pre_rst_count", {28'd0, count}, 32'd5);
    chk("pre_rst_valid", {31'd0, valid_out}, 32'd1);
    pop = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    mdl.delete();
    m_over = 1'b0;
    m_under = 1'b0;
    @(posedge clk);
    #1;
    pop = 1'b0;
    rst = 1'b0;
    chk_reset_state("held_rst");

    // Resume after reset.
    step(1'b1, 16'h0777, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    chk("resume_data", {16'd0, data_out}, 32'h0777);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/class_input_fifo.md
# class_input_fifo

Per-class ingress buffer that sits directly upstream of the four-input round-robin scheduler block. One instance feeds each of its r0..r3 data inputs. It stores DATA_WIDTH-bit words written by the producer and releases one word per pop. When no word is released it presents an all-zero word, which the scheduler treats as an idle slot. It also produces occupancy flags and sticky error flags for backpressure and debug.

## Interface
- DATA_WIDTH, 16, width of each stored word and of data_in/data_out.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH (8 by default).
- ALMOST_FULL, 6, almost_full asserts when count >= this value.
- ALMOST_EMPTY, 2, almost_empty asserts when count <= this value.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- push  input  1  write request for data_in this cycle.
- data_in  input  DATA_WIDTH  word to store.
- pop  input  1  read request this cycle.
- data_out  output  DATA_WIDTH  popped word (registered); zero when valid_out=0; connects to scheduler r0..r3.
- valid_out  output  1  data_out carries a popped word this cycle.
- count  output  ADDR_WIDTH+1  current occupancy, 0..depth.
- full, empty  output  1  count==depth, count==0.
- almost_full, almost_empty  output  1  threshold flags per parameters.
- overflow, underflow  output  1  sticky error flags, cleared only by rst.

## Operation
- Storage: circular buffer of depth words, write pointer wr_ptr, read pointer rd_ptr, each ADDR_WIDTH bits. Both wrap naturally from depth-1 to 0. Occupancy is tracked in a separate count register, so pointer equality is not used to tell full from empty.
- Push is accepted if full=0, or if full=1 and an accepted pop occurs in the same cycle. Accepted push: mem[wr_ptr]<=data_in, wr_ptr+1.
- Pop is accepted if empty=0. A push in the same cycle does not help: there is no fall-through.
  - Accepted pop: data_out<=mem[rd_ptr], valid_out<=1, rd_ptr+1.
  - Otherwise: data_out<=0, valid_out<=0.
- count next = count + accepted_push − accepted_pop. Push and pop both accepted leaves count unchanged.
- Rejected push (full and no accepted pop): data is dropped, pointers and count are unchanged, overflow<=1.
- Rejected pop (empty): underflow<=1, data_out<=0.
- Flags are decoded from the count register only, so they reflect state after the last edge.
- Reset (async assert, any time, including mid-transfer):
  - wr_ptr=rd_ptr=0, count=0.
  - data_out=0, valid_out=0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - overflow=0, underflow=0.
  - Memory contents are don't-care and are never observable after reset.
  - Operation resumes on the first rising edge after rst deasserts.

## Timing
- Pop latency: 1 cycle. Pop sampled at edge N gives the word on data_out/valid_out after edge N, held for one cycle only.
- Push-to-pop minimum: a word pushed at edge N is poppable at edge N+1, so it appears on data_out after edge N+1.
- count and all flags update at the same edge as the accepted push/pop that changes them.
- overflow/underflow set at the edge of the offending request and stay set.
- Back-to-back pops: one word per cycle, order strictly FIFO across pointer wrap.

## Test plan
- Reset check: assert rst mid-run with count=5 and pop active. Required: data_out=0, valid_out=0, count=0, empty=1, almost_empty=1, errors=0 immediately, without waiting for a clock edge.
- Fill/drain with wrap:
  - Push 0x0001..0x0008. Required: count=8, full=1, almost_full asserts when count reaches 6.
  - Pop 3, push 0x0009..0x000B, then pop 8. Required: output sequence 0x0001..0x000B in order, each 1 cycle after its pop, with empty=1 at the end.
- Overflow: with full=1, push 0xDEAD with no pop. Required: count stays 8, overflow=1, 0xDEAD never appears on data_out.
- Full push+pop: with full=1 (contents 0x0001..0x0008), push 0x00AA with pop in the same cycle. Required: data_out=0x0001, count stays 8, overflow=0, and 0x00AA is the 8th word popped afterwards.
- Empty push+pop: on an empty FIFO, push 0x0055 with pop in the same cycle. Required: valid_out=0, data_out=0, underflow=1, count=1. The next pop returns 0x0055.
- Idle output: with no pops for 10 cycles, data_out=0x0000 and valid_out=0 every cycle, while the scheduler downstream sees an idle slot.
